ccff_stream_loader: RTL and testbench
=====================================

CCFF_STREAM_LOADER -- requirements
Module: ccff_stream_loader

Interface
REQ-001 SHALL have parameter WORD_W, default 32, meaning the width of the incoming bitstream word.
REQ-002 SHALL have parameter CHAIN_LEN, default 1024, meaning the number of configuration-chain bits to load; legal range 1..65535.
REQ-003 SHALL have port prog_clk, input, 1, the single clock; all state is updated on its rising edge.
REQ-004 SHALL have port pReset, input, 1, an asynchronous active-high reset.
REQ-005 SHALL have port start, input, 1, a request to begin one load sequence.
REQ-006 SHALL have port word_data, input, WORD_W, the bitstream word from the upstream stage.
REQ-007 SHALL have port word_valid, input, 1, indicating word_data is valid.
REQ-008 SHALL have port word_ready, output, 1, indicating the block accepts a word this cycle.
REQ-009 SHALL have port ccff_head, output, 1, the serial bit driven into the configuration-chain head.
REQ-010 SHALL have port config_enable, output, 1, the chain shift enable.
REQ-011 SHALL have port busy, output, 1, high whenever the state is not IDLE.
REQ-012 SHALL have port done, output, 1, a one-cycle pulse on successful completion.
REQ-013 SHALL have port error, output, 1, a sticky CRC-mismatch flag.

Function
REQ-014 SHALL implement the states IDLE, FETCH, SHIFT, CHECK and FINISH.
REQ-015 IDLE: start=1 SHALL clear the bit counter, clear error, and move to FETCH on the next edge; start SHALL be ignored in every other state.
REQ-016 FETCH: word_ready SHALL be 1; when word_valid=1 and word_ready=1 on an edge, the word SHALL be latched into the shift register and the state SHALL move to SHIFT.
REQ-017 SHIFT: config_enable SHALL be 1; ccff_head SHALL equal the shift-register LSB; the register SHALL shift right one bit per cycle and the bit counter SHALL increment.
REQ-018 SHIFT exit: after WORD_W bits, the state SHALL return to FETCH; when the counter reaches CHAIN_LEN, it SHALL move to CHECK (CRC macro defined) or FINISH (macro undefined), whichever applies first.
REQ-019 In a partial final word, only the low CHAIN_LEN mod WORD_W bits SHALL be shifted; the remaining upper bits SHALL be discarded.
REQ-020 Exactly CHAIN_LEN cycles with config_enable=1 SHALL occur per load; config_enable SHALL be 0 in IDLE, FETCH, CHECK and FINISH.
REQ-021 Backpressure: while in FETCH with word_valid=0, the block SHALL wait indefinitely with config_enable=0, and no bit SHALL be lost.
REQ-022 FINISH: done SHALL be 1 for exactly one cycle, after which the state SHALL return to IDLE.
REQ-023 word_ready SHALL be 0 outside FETCH and CHECK.
REQ-024 ccff_head SHALL be 0 whenever config_enable=0.

Reset
REQ-025 pReset=1 SHALL asynchronously force state=IDLE, counter=0, shift register=0, CRC=16'hFFFF, and all outputs=0, including word_ready and error.
REQ-026 Reset asserted mid-load SHALL abort the load immediately; there SHALL be no resume, and the next load SHALL require a new start.

Configuration
REQ-027 Macro CCFF_STREAM_CRC_EN defined: the block SHALL compute CRC-16-CCITT (poly 0x1021, init 0xFFFF, MSB-first update) over each bit as it is driven on ccff_head.
REQ-028 CHECK, with the macro defined: word_ready SHALL be 1; on handshake, word_data[15:0] SHALL be compared with the CRC; a match SHALL go to FINISH, and a mismatch SHALL set error=1 and return to IDLE without done.
REQ-029 Macro undefined: there SHALL be no CHECK state and no CRC logic, and error SHALL be tied to 0.

Structure
REQ-030 A shared package ccff_stream_pkg SHALL hold the state enumeration type, CRC_POLY=16'h1021 and CRC_INIT=16'hFFFF.
REQ-031 A single sub-module ccff_crc16_serial (1-bit CRC update with enable and clear) SHALL be instantiated only under CCFF_STREAM_CRC_EN.
REQ-032 The bit-counter width SHALL be $clog2(CHAIN_LEN+1).

Verification
REQ-033 CHAIN_LEN=40, words 32'hA5A5_0001 and 32'h0000_00F3 with word_valid held high: config_enable high for 40 cycles total, ccff_head bits equal word0[0..31] then word1[0..7], and done pulses once.
REQ-034 Same stimulus with word_valid dropped for 5 cycles between words: a 5-cycle config_enable gap occurs, and the serial bit sequence is identical to REQ-033.
REQ-035 CRC macro defined, CHAIN_LEN=8, data 8'h31: a CHECK word with [15:0] equal to the computed CRC-16-CCITT gives done=1 and error=0; a CHECK word of 16'h0000 gives error=1 and no done.
REQ-036 pReset pulsed at bit 17 of a 40-bit load: all outputs are 0 immediately, start ignored while reset is held, and a new start performs a full 40-bit load.
REQ-037 start asserted during SHIFT: no effect, and the bit count and done timing are unchanged.
REQ-038 CHAIN_LEN=1: exactly one config_enable cycle, ccff_head=word_data[0], and done follows.

Source files
------------

// File: rtl/ccff_stream_pkg.sv
// Shared types and CRC constants for the configuration-chain stream loader.
// CCFF_STREAM_CRC_EN adds the CHECK state used to verify a trailing CRC word.
package ccff_stream_pkg;

  localparam logic [15:0] CRC_POLY = 16'h1021;
  localparam logic [15:0] CRC_INIT = 16'hFFFF;

`ifdef CCFF_STREAM_CRC_EN
  typedef enum logic [2:0] {StIdle, StFetch, StShift, StCheck, StFinish} state_e;
`else
  typedef enum logic [2:0] {StIdle, StFetch, StShift, StFinish} state_e;
`endif

  // One MSB-first CRC-16-CCITT update for a single serial bit.
  function automatic logic [15:0] crc16_step(input logic [15:0] crc, input logic din);
    logic fb;
    fb = crc[15] ^ din;
    return {crc[14:0], 1'b0} ^ (fb ? CRC_POLY : 16'h0000);
  endfunction

endpackage

// File: rtl/ccff_crc16_serial.sv
// Bit-serial CRC-16-CCITT accumulator with synchronous clear and update enable.
module ccff_crc16_serial
  import ccff_stream_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        clr_i,
  input  logic        en_i,
  input  logic        bit_i,
  output logic [15:0] crc_o
);

  logic [15:0] crc_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      crc_q <= CRC_INIT;
    end else if (clr_i) begin
      crc_q <= CRC_INIT;
    end else if (en_i) begin
      crc_q <= crc16_step(crc_q, bit_i);
    end
  end

  assign crc_o = crc_q;

endmodule

// File: rtl/ccff_stream_loader.sv
// Streams bitstream words LSB-first into a configuration chain of CHAIN_LEN bits.
// Define CCFF_STREAM_CRC_EN to check a trailing CRC-16-CCITT word before done.
module ccff_stream_loader
  import ccff_stream_pkg::*;
#(
  parameter int unsigned WORD_W    = 32,
  parameter int unsigned CHAIN_LEN = 1024
) (
  input  logic              prog_clk,
  input  logic              pReset,
  input  logic              start,
  input  logic [WORD_W-1:0] word_data,
  input  logic              word_valid,
  output logic              word_ready,
  output logic              ccff_head,
  output logic              config_enable,
  output logic              busy,
  output logic              done,
  output logic              error
);

  localparam int unsigned CNT_W  = $clog2(CHAIN_LEN + 1);
  localparam int unsigned WCNT_W = (WORD_W > 1) ? $clog2(WORD_W) : 1;
  localparam logic [CNT_W-1:0]  LAST_BIT  = CNT_W'(CHAIN_LEN - 1);
  localparam logic [WCNT_W-1:0] LAST_WBIT = WCNT_W'(WORD_W - 1);

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    bit_cnt_q, bit_cnt_d;
  logic [WCNT_W-1:0]   wcnt_q, wcnt_d;
  logic [WORD_W-1:0]   sreg_q, sreg_d;

`ifdef CCFF_STREAM_CRC_EN
  logic        error_q, error_d;
  logic        crc_clr, crc_en;
  logic [15:0] crc;

  ccff_crc16_serial u_crc (
    .clk_i (prog_clk),
    .rst_i (pReset),
    .clr_i (crc_clr),
    .en_i  (crc_en),
    .bit_i (sreg_q[0]),
    .crc_o (crc)
  );

  assign error = error_q;
`else
  assign error = 1'b0;
`endif

  always_ff @(posedge prog_clk or posedge pReset) begin
    if (pReset) begin
      state_q   <= StIdle;
      bit_cnt_q <= '0;
      wcnt_q    <= '0;
      sreg_q    <= '0;
`ifdef CCFF_STREAM_CRC_EN
      error_q   <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      wcnt_q    <= wcnt_d;
      sreg_q    <= sreg_d;
`ifdef CCFF_STREAM_CRC_EN
      error_q   <= error_d;
`endif
    end
  end

  always_comb begin
    state_d       = state_q;
    bit_cnt_d     = bit_cnt_q;
    wcnt_d        = wcnt_q;
    sreg_d        = sreg_q;
    word_ready    = 1'b0;
    config_enable = 1'b0;
    ccff_head     = 1'b0;
    done          = 1'b0;
`ifdef CCFF_STREAM_CRC_EN
    error_d       = error_q;
    crc_clr       = 1'b0;
    crc_en        = 1'b0;
`endif
    unique case (state_q)
      StIdle: begin
        if (start) begin
          bit_cnt_d = '0;
          state_d   = StFetch;
`ifdef CCFF_STREAM_CRC_EN
          error_d   = 1'b0;
          crc_clr   = 1'b1;
`endif
        end
      end
      StFetch: begin
        word_ready = 1'b1;
        if (word_valid) begin
          sreg_d  = word_data;
          wcnt_d  = '0;
          state_d = StShift;
        end
      end
      StShift: begin
        config_enable = 1'b1;
        ccff_head     = sreg_q[0];
        sreg_d        = sreg_q >> 1;
        bit_cnt_d     = bit_cnt_q + CNT_W'(1);
        wcnt_d        = wcnt_q + WCNT_W'(1);
`ifdef CCFF_STREAM_CRC_EN
        crc_en        = 1'b1;
`endif
        // Chain end wins over word end, so upper bits of a partial last word are dropped.
        if (bit_cnt_q == LAST_BIT) begin
`ifdef CCFF_STREAM_CRC_EN
          state_d = StCheck;
`else
          state_d = StFinish;
`endif
        end else if (wcnt_q == LAST_WBIT) begin
          state_d = StFetch;
        end
      end
`ifdef CCFF_STREAM_CRC_EN
      StCheck: begin
        word_ready = 1'b1;
        if (word_valid) begin
          if (word_data[15:0] == crc) begin
            state_d = StFinish;
          end else begin
            error_d = 1'b1;
            state_d = StIdle;
          end
        end
      end
`endif
      StFinish: begin
        done    = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  assign busy = (state_q != StIdle);

endmodule

// File: tb/tb_ccff_stream_loader.sv
// Directed self-checking bench for ccff_stream_loader (CHAIN_LEN 1 and 40, plus 8 with CRC).
module tb_ccff_stream_loader;

  logic prog_clk = 1'b0;
  logic pReset;
  int   checks = 0;
  int   errors = 0;

  always #5 prog_clk = ~prog_clk;

  // CHAIN_LEN = 1 instance
  logic        s1, v1, r1, h1, ce1, b1, dn1, e1;
  logic [31:0] d1;
  // CHAIN_LEN = 40 instance
  logic        s40, v40, r40, h40, ce40, b40, dn40, e40;
  logic [31:0] d40;

  ccff_stream_loader #(.WORD_W(32), .CHAIN_LEN(1)) u_dut1 (
    .prog_clk(prog_clk), .pReset(pReset), .start(s1), .word_data(d1), .word_valid(v1),
    .word_ready(r1), .ccff_head(h1), .config_enable(ce1), .busy(b1), .done(dn1), .error(e1)
  );

  ccff_stream_loader #(.WORD_W(32), .CHAIN_LEN(40)) u_dut40 (
    .prog_clk(prog_clk), .pReset(pReset), .start(s40), .word_data(d40), .word_valid(v40),
    .word_ready(r40), .ccff_head(h40), .config_enable(ce40), .busy(b40), .done(dn40),
    .error(e40)
  );

`ifdef CCFF_STREAM_CRC_EN
  logic        s8, v8, r8, h8, ce8, b8, dn8, e8;
  logic [31:0] d8;

  ccff_stream_loader #(.WORD_W(32), .CHAIN_LEN(8)) u_dut8 (
    .prog_clk(prog_clk), .pReset(pReset), .start(s8), .word_data(d8), .word_valid(v8),
    .word_ready(r8), .ccff_head(h8), .config_enable(ce8), .busy(b8), .done(dn8), .error(e8)
  );
`endif

  typedef struct {
    logic        start;
    logic        valid;
    logic [31:0] data;
    logic        ready;
    logic        ce;
    logic        head;
    logic        busy;
    logic        done;
  } vec_t;

  vec_t tbl[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge prog_clk);
    #1;
  endtask

  task automatic add(input logic st, input logic va, input logic [31:0] da, input logic rd,
                     input logic ce, input logic hd, input logic bs, input logic dn);
    vec_t v;
    v.start = st; v.valid = va; v.data = da;
    v.ready = rd; v.ce = ce; v.head = hd; v.busy = bs; v.done = dn;
    tbl.push_back(v);
  endtask

  function automatic logic [15:0] crc_bit(input logic [15:0] c, input logic b);
    logic fb;
    fb = c[15] ^ b;
    return {c[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
  endfunction

  // Runs one 40-bit load; stall drops word_valid for that many FETCH cycles before word 1.
  task automatic load40(input int stall, input bit poke, output int nbits, output int ndone,
                        output int done_cyc, output int gap, output int leak,
                        output logic [39:0] bits);
    logic [31:0] w [3];
    logic [39:0] exp;
    logic [15:0] c;
    int          widx;
    int          stalled;
    logic        took;
    w[0] = 32'hA5A5_0001;
    w[1] = 32'h0000_00F3;
    exp  = {w[1][7:0], w[0]};
    c    = 16'hFFFF;
    for (int i = 0; i < 40; i++) c = crc_bit(c, exp[i]);
    w[2] = {16'h0000, c};
    nbits = 0; ndone = 0; done_cyc = -1; gap = 0; leak = 0; bits = '0;
    widx = 0; stalled = 0;
    s40 = 1'b1; v40 = 1'b0;
    step();
    s40 = 1'b0;
    for (int cyc = 1; cyc < 120; cyc++) begin
      if (ce40) begin
        if (nbits < 40) bits[nbits] = h40;
        nbits++;
        if (r40) leak++;
      end else begin
        if (h40) leak++;
        if (nbits > 0 && nbits < 40) gap++;
      end
      if (dn40) begin
        ndone++;
        done_cyc = cyc;
      end
      if (!b40) break;
      v40 = 1'b0;
      s40 = poke && ce40;
      if (r40 && widx < 3) begin
        if (widx == 1 && stalled < stall) begin
          stalled++;
          d40 = 32'hDEAD_BEEF;
        end else begin
          v40 = 1'b1;
          d40 = w[widx];
        end
      end
      took = v40 && r40;
      step();
      if (took) widx++;
    end
    s40 = 1'b0;
    v40 = 1'b0;
  endtask

  initial begin
    int          nb, nd, dc, gp, lk, dc_ref, gp_ref, n;
    logic [39:0] bits;
    int          done_exp;
`ifdef CCFF_STREAM_CRC_EN
    logic [15:0] c8;
    done_exp = 44;
`else
    done_exp = 43;
`endif

    pReset = 1'b1;
    s1 = 0; v1 = 0; d1 = '0;
    s40 = 0; v40 = 0; d40 = '0;
`ifdef CCFF_STREAM_CRC_EN
    s8 = 0; v8 = 0; d8 = '0;
`endif
    #2;
    check("reset busy", b40, 1'b0);
    check("reset ready", r40, 1'b0);
    check("reset ce", ce40, 1'b0);
    check("reset error", e40, 1'b0);
    @(posedge prog_clk);
    #1;
    pReset = 1'b0;

    // CHAIN_LEN=1 cycle table; CHECK rows carry the hand-computed CRC of one bit.
    add(0, 0, 32'h0,         0, 0, 0, 0, 0);
    add(1, 0, 32'h0,         0, 0, 0, 0, 0);
    add(0, 0, 32'hFFFF_FFFF, 1, 0, 0, 1, 0);
    add(0, 1, 32'h0000_0003, 1, 0, 0, 1, 0);
    add(1, 0, 32'h0,         0, 1, 1, 1, 0);
`ifdef CCFF_STREAM_CRC_EN
    add(0, 1, 32'h0000_FFFE, 1, 0, 0, 1, 0);
`endif
    add(1, 0, 32'h0,         0, 0, 0, 1, 1);
    add(0, 0, 32'h0,         0, 0, 0, 0, 0);
    add(1, 0, 32'h0,         0, 0, 0, 0, 0);
    add(0, 1, 32'hFFFF_FFFE, 1, 0, 0, 1, 0);
    add(0, 0, 32'h0,         0, 1, 0, 1, 0);
`ifdef CCFF_STREAM_CRC_EN
    add(0, 1, 32'h0000_EFDF, 1, 0, 0, 1, 0);
`endif
    add(0, 0, 32'h0,         0, 0, 0, 1, 1);
    add(0, 0, 32'h0,         0, 0, 0, 0, 0);

    foreach (tbl[i]) begin
      s1 = tbl[i].start; v1 = tbl[i].valid; d1 = tbl[i].data;
      check($sformatf("len1 row%0d ready", i), r1, tbl[i].ready);
      check($sformatf("len1 row%0d ce", i), ce1, tbl[i].ce);
      check($sformatf("len1 row%0d head", i), h1, tbl[i].head);
      check($sformatf("len1 row%0d busy", i), b1, tbl[i].busy);
      check($sformatf("len1 row%0d done", i), dn1, tbl[i].done);
      check($sformatf("len1 row%0d error", i), e1, 1'b0);
      step();
    end
    s1 = 0; v1 = 0;

    // Streaming with word_valid held high.
    load40(0, 0, nb, nd, dc, gp, lk, bits);
    check("len40 ce cycles", nb, 40);
    check("len40 bits", bits, 40'hF3_A5A5_0001);
    check("len40 done pulses", nd, 1);
    check("len40 done cycle", dc, done_exp);
    check("len40 fetch gap", gp, 1);
    check("len40 head/ready leak", lk, 0);
    check("len40 error", e40, 1'b0);
    dc_ref = dc;
    gp_ref = gp;

    // Five stalled FETCH cycles before word 1.
    load40(5, 0, nb, nd, dc, gp, lk, bits);
    check("stall ce cycles", nb, 40);
    check("stall bits", bits, 40'hF3_A5A5_0001);
    check("stall done pulses", nd, 1);
    check("stall extra gap", gp - gp_ref, 5);
    check("stall done cycle", dc, done_exp + 5);
    check("stall head/ready leak", lk, 0);

    // start held during every SHIFT cycle.
    load40(0, 1, nb, nd, dc, gp, lk, bits);
    check("poke ce cycles", nb, 40);
    check("poke bits", bits, 40'hF3_A5A5_0001);
    check("poke done pulses", nd, 1);
    check("poke done cycle", dc, dc_ref);
    check("poke idle after", b40, 1'b0);

    // Reset mid-load at bit 17.
    s40 = 1'b1;
    step();
    s40 = 1'b0; v40 = 1'b1; d40 = 32'hA5A5_0001;
    n = 0;
    for (int cyc = 0; cyc < 60; cyc++) begin
      if (ce40) n++;
      if (n == 17) break;
      step();
    end
    v40 = 1'b0;
    check("abort reached bit 17", n, 17);
    #2;
    pReset = 1'b1;
    #1;
    check("abort ready", r40, 1'b0);
    check("abort ce", ce40, 1'b0);
    check("abort head", h40, 1'b0);
    check("abort busy", b40, 1'b0);
    check("abort done", dn40, 1'b0);
    check("abort error", e40, 1'b0);
    s40 = 1'b1;
    step();
    step();
    check("start under reset", b40, 1'b0);
    pReset = 1'b0;
    s40 = 1'b0;
    step();
    check("no resume", b40, 1'b0);
    check("no resume ce", ce40, 1'b0);
    load40(0, 0, nb, nd, dc, gp, lk, bits);
    check("reload ce cycles", nb, 40);
    check("reload bits", bits, 40'hF3_A5A5_0001);
    check("reload done pulses", nd, 1);

`ifdef CCFF_STREAM_CRC_EN
    // CHAIN_LEN=8, data 0x31 with garbage upper bits; good then bad CRC word.
    c8 = 16'hFFFF;
    for (int i = 0; i < 8; i++) c8 = crc_bit(c8, (8'h31 >> i) & 8'h1);
    for (int pass = 0; pass < 2; pass++) begin
      s8 = 1'b1;
      step();
      s8 = 1'b0;
      check($sformatf("crc%0d error cleared", pass), e8, 1'b0);
      v8 = 1'b1; d8 = 32'hFFFF_FF31;
      step();
      v8 = 1'b0;
      n = 0;
      for (int cyc = 0; cyc < 20; cyc++) begin
        if (ce8) n++;
        if (r8) break;
        step();
      end
      check($sformatf("crc%0d ce cycles", pass), n, 8);
      v8 = 1'b1;
      d8 = (pass == 0) ? {16'h0000, c8} : 32'h0;
      step();
      v8 = 1'b0;
      check($sformatf("crc%0d done", pass), dn8, (pass == 0) ? 1'b1 : 1'b0);
      check($sformatf("crc%0d error", pass), e8, (pass == 0) ? 1'b0 : 1'b1);
      check($sformatf("crc%0d busy", pass), b8, (pass == 0) ? 1'b1 : 1'b0);
      step();
      check($sformatf("crc%0d idle", pass), b8, 1'b0);
      check($sformatf("crc%0d error sticky", pass), e8, (pass == 0) ? 1'b0 : 1'b1);
    end
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
